i2c_tx_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO that buffers bytes from the host/register side and feeds the I2C master controller's transmit path. The host pushes the address/R-W byte followed by payload bytes. The controller watches `empty`, takes the head word from `data_out`, and pops it with a one-cycle `read` pulse. Occupancy and error flags go back to the host-side status logic.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_fifo_mem.sv | 26 ++
 rtl/i2c_tx_fifo.sv | 87 ++++++++
 tb/tb_i2c_tx_fifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: default widths/depths and a clog2-style width helper
// used by the TX/RX FIFOs and the controller.
package i2c_pkg;

  localparam int I2C_DATA_WIDTH    = 8;
  localparam int I2C_TX_FIFO_DEPTH = 16;

  // Smallest w with 2**w >= value; returns 0 for value <= 1.
  function automatic int i2c_clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/i2c_fifo_mem.sv
// Register-array storage for the I2C FIFOs: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module i2c_fifo_mem
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int DEPTH      = I2C_TX_FIFO_DEPTH,
  localparam int ADDR_WIDTH = i2c_clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_tx_fifo.sv
// First-word-fall-through TX FIFO between host registers and the I2C master.
// Define I2C_TX_FIFO_ERR_EN to add the sticky overflow/underflow flags.
module i2c_tx_fifo
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int DEPTH      = I2C_TX_FIFO_DEPTH,
  localparam int ADDR_WIDTH = i2c_clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   usedw
`ifdef I2C_TX_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] head;
  logic                  read_ok;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty = (count == '0);
  assign usedw = count;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write.
  assign read_ok = read & ~empty;
  assign do_rd   = read_ok;
  assign do_wr   = write & (~full | read_ok);

  i2c_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (do_wr & ~clear & ~reset),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(head)
  );

  assign data_out = empty ? '0 : head;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef I2C_TX_FIFO_ERR_EN
  // A read paired with a write on an empty FIFO is not an underflow: the write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write & full & ~read)  overflow  <= 1'b1;
      if (read & empty & ~write) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Self-checking bench for i2c_tx_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model. Error-flag checks follow I2C_TX_FIFO_ERR_EN.
module tb_i2c_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       write = 1'b0;
  logic [7:0] data_in = '0;
  logic       read = 1'b0;
  logic       full;
  logic       empty;
  logic [7:0] data_out;
  logic [4:0] usedw;
`ifdef I2C_TX_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  i2c_tx_fifo dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .write   (write),
    .data_in (data_in),
    .full    (full),
    .read    (read),
    .data_out(data_out),
    .empty   (empty),
    .usedw   (usedw)
`ifdef I2C_TX_FIFO_ERR_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: a bounded queue of words, judged on the state before the edge.
  task automatic model_update(input logic w, input logic [7:0] d, input logic r,
                              input logic c, input logic rs);
    bit popped, pushed;
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && q.size() == DEPTH && !r) m_ovf = 1'b1;
      if (r && q.size() == 0 && !w)     m_unf = 1'b1;
      if (c) begin
        q.delete();
      end else begin
        popped = r && (q.size() > 0);
        pushed = w && ((q.size() < DEPTH) || popped);
        if (popped) void'(q.pop_front());
        if (pushed) q.push_back(d);
      end
    end
  endtask

  task automatic check_all();
    chk("empty", {15'd0, empty}, {15'd0, q.size() == 0});
    chk("full", {15'd0, full}, {15'd0, q.size() == DEPTH});
    chk("usedw", {11'd0, usedw}, 16'(q.size()));
    chk("data_out", {8'd0, data_out}, {8'd0, (q.size() > 0) ? q[0] : 8'h00});
`ifdef I2C_TX_FIFO_ERR_EN
    chk("overflow", {15'd0, overflow}, {15'd0, m_ovf});
    chk("underflow", {15'd0, underflow}, {15'd0, m_unf});
`endif
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic c, input logic rs);
    write = w; data_in = d; read = r; clear = c; reset = rs;
    @(posedge clk);
    model_update(w, d, r, c, rs);
    #1;
    check_all();
    write = 1'b0; read = 1'b0; clear = 1'b0; reset = 1'b0;
  endtask

  initial begin
    int exp_idx;
    int guard;
    logic sv_ovf, sv_unf;

    // reset values
    @(negedge clk);
    step(0, 8'h00, 0, 0, 1);
    chk("rst_empty", {15'd0, empty}, 16'd1);
    chk("rst_usedw", {11'd0, usedw}, 16'd0);
    chk("rst_data", {8'd0, data_out}, 16'd0);

    // FWFT latency
    step(1, 8'hA0, 0, 0, 0);
    chk("fwft_a0", {8'd0, data_out}, 16'h00A0);
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    chk("usedw3", {11'd0, usedw}, 16'd3);
    step(0, 8'h00, 0, 1, 0);

    // fill, overflow attempt
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hFF, 0, 0, 0);
    chk("full_after_fill", {15'd0, full}, 16'd1);
    chk("usedw16", {11'd0, usedw}, 16'd16);
`ifdef I2C_TX_FIFO_ERR_EN
    chk("ovf_set", {15'd0, overflow}, 16'd1);
`endif

    // simultaneous push/pop while full
    step(1, 8'h55, 1, 0, 0);
    chk("full_rw_usedw", {11'd0, usedw}, 16'd16);
    chk("full_rw_head", {8'd0, data_out}, 16'h0001);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("word16_is_55", {8'd0, data_out}, 16'h0055);
      else chk("drain_no_ff", {15'd0, data_out == 8'hFF}, 16'd0);
      step(0, 8'h00, 1, 0, 0);
    end
    chk("drained", {15'd0, empty}, 16'd1);

    // read+write on empty
    step(1, 8'h3C, 1, 0, 0);
    chk("rw_empty_usedw", {11'd0, usedw}, 16'd1);
    chk("rw_empty_data", {8'd0, data_out}, 16'h003C);
`ifdef I2C_TX_FIFO_ERR_EN
    chk("rw_empty_unf", {15'd0, underflow}, 16'd0);
`endif
    step(0, 8'h00, 0, 1, 0);

    // streaming across pointer wraps
    exp_idx = 0;
    for (int i = 0; i < 40; i++) begin
      if (!empty) begin
        chk("stream", {8'd0, data_out}, 16'(exp_idx));
        exp_idx++;
      end
      step(1, 8'(i), !empty, 0, 0);
    end
    guard = 0;
    while (!empty && guard < 100) begin
      chk("stream", {8'd0, data_out}, 16'(exp_idx));
      exp_idx++;
      guard++;
      step(0, 8'h00, 1, 0, 0);
    end
    chk("stream_count", 16'(exp_idx), 16'd40);
    chk("stream_end_empty", {15'd0, empty}, 16'd1);

    // clear with concurrent write
    for (int i = 0; i < 5; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
    sv_ovf = m_ovf;
    sv_unf = m_unf;
    step(1, 8'hEE, 0, 1, 0);
    chk("clr_empty", {15'd0, empty}, 16'd1);
    chk("clr_usedw", {11'd0, usedw}, 16'd0);
    chk("clr_data", {8'd0, data_out}, 16'd0);
`ifdef I2C_TX_FIFO_ERR_EN
    chk("clr_keeps_ovf", {15'd0, overflow}, {15'd0, sv_ovf});
    chk("clr_keeps_unf", {15'd0, underflow}, {15'd0, sv_unf});
`endif

    // randomized traffic with shifting write/read bias
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      wp = ((i / 200) % 2 == 0) ? 75 : 30;
      rp = 100 - wp;
      step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
           $urandom_range(0, 99) == 0, $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
